// File: rtl/sound_pkg.sv
// Shared definitions for the sound sequencer: state encoding and the
// millisecond-to-cycle conversion used to size the beep timer loads.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VEND_TONE = 2'd1,
        ERR_TONE  = 2'd2,
        ERR_GAP   = 2'd3
    } state_t;

    function automatic logic [31:0] ms_to_cycles(input logic [31:0] clock_hz,
                                                 input logic [31:0] ms);
        return (clock_hz / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/beep_timer.sv
// Loadable 32-bit down-counter shared by every timed state of the sequencer.
module beep_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic        done
);

    logic [31:0] count_r;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (load) begin
            count_r <= value;
        end else if (count_r != 32'd0) begin
            count_r <= count_r - 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // The sequencer reloads only when it sees done, so done looks at the
    // count alone; folding load into it would close a combinational loop.
    assign done = (count_r == 32'd0);

endmodule

// File: rtl/sound_sequencer.sv
// Turns single-cycle vend/error requests into timed beep patterns for the
// square-wave tone generator.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned CLOCK_HZ      = 32'd100_000_000,
    parameter int unsigned VEND_BEEP_MS  = 32'd200,
    parameter int unsigned ERROR_BEEP_MS = 32'd100,
    parameter int unsigned ERROR_GAP_MS  = 32'd100,
    parameter int unsigned ERROR_BEEPS   = 32'd3
) (
    input  logic clk,
    input  logic rst,
    input  logic vend_pulse,
    input  logic error_pulse,
    output logic vend_event,
    output logic error_event,
    output logic busy
);

    localparam logic [31:0] VEND_CYC = ms_to_cycles(32'(CLOCK_HZ), 32'(VEND_BEEP_MS));
    localparam logic [31:0] ERR_CYC  = ms_to_cycles(32'(CLOCK_HZ), 32'(ERROR_BEEP_MS));
    localparam logic [31:0] GAP_CYC  = ms_to_cycles(32'(CLOCK_HZ), 32'(ERROR_GAP_MS));
    localparam int          BW       = $clog2(ERROR_BEEPS + 1);
    localparam logic [BW-1:0] LAST_BEEP = BW'(ERROR_BEEPS - 1);

    state_t          state_r;
    logic [BW-1:0]   beep_cnt_r;
    logic            load_s;
    logic [31:0]     value_s;
    logic            done_s;

    beep_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .value (value_s),
        .done  (done_s)
    );

    // Timer reload on every state transition, with the new state's duration.
    always_comb begin
        load_s  = 1'b0;
        value_s = 32'd0;
        case (state_r)
            IDLE: begin
                if (error_pulse) begin
                    load_s  = 1'b1;
                    value_s = ERR_CYC - 32'd1;
                end else if (vend_pulse) begin
                    load_s  = 1'b1;
                    value_s = VEND_CYC - 32'd1;
                end else begin
                    load_s  = 1'b0;
                end
            end
            VEND_TONE: begin
                if (error_pulse) begin
                    load_s  = 1'b1;
                    value_s = ERR_CYC - 32'd1;
                end else if (done_s) begin
                    load_s  = 1'b1;
                end else begin
                    load_s  = 1'b0;
                end
            end
            ERR_TONE: begin
                if (done_s && beep_cnt_r != LAST_BEEP) begin
                    load_s  = 1'b1;
                    value_s = GAP_CYC - 32'd1;
                end else if (done_s) begin
                    load_s  = 1'b1;
                end else begin
                    load_s  = 1'b0;
                end
            end
            ERR_GAP: begin
                if (done_s) begin
                    load_s  = 1'b1;
                    value_s = ERR_CYC - 32'd1;
                end else begin
                    load_s  = 1'b0;
                end
            end
            default: begin
                load_s  = 1'b0;
                value_s = 32'd0;
            end
        endcase
    end

    // Pattern FSM with registered tone and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            beep_cnt_r  <= '0;
            vend_event  <= 1'b0;
            error_event <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (error_pulse) begin
                        state_r     <= ERR_TONE;
                        beep_cnt_r  <= '0;
                        error_event <= 1'b1;
                        busy        <= 1'b1;
                    end else if (vend_pulse) begin
                        state_r    <= VEND_TONE;
                        vend_event <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                VEND_TONE: begin
                    if (error_pulse) begin
                        state_r     <= ERR_TONE;
                        beep_cnt_r  <= '0;
                        vend_event  <= 1'b0;
                        error_event <= 1'b1;
                    end else if (done_s) begin
                        state_r    <= IDLE;
                        vend_event <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        state_r <= VEND_TONE;
                    end
                end
                ERR_TONE: begin
                    if (done_s) begin
                        beep_cnt_r  <= beep_cnt_r + BW'(1);
                        error_event <= 1'b0;
                        if (beep_cnt_r != LAST_BEEP) begin
                            state_r <= ERR_GAP;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        state_r <= ERR_TONE;
                    end
                end
                ERR_GAP: begin
                    if (done_s) begin
                        state_r     <= ERR_TONE;
                        error_event <= 1'b1;
                    end else begin
                        state_r <= ERR_GAP;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    vend_event  <= 1'b0;
                    error_event <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: directed scenarios then random
// requests and resets, compared against a timeline model of the beep patterns.
module tb_sound_sequencer;

    localparam int V = 4;   // vend beep cycles
    localparam int E = 2;   // error beep cycles
    localparam int G = 3;   // gap cycles
    localparam int B = 3;   // beeps per error pattern

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vend_pulse = 1'b0;
    logic error_pulse = 1'b0;
    logic vend_event, error_event, busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: current pattern kind (0 none, 1 vend, 2 error) and its start edge.
    int mode = 0;
    int start_edge = 0;
    int edge_no = 0;
    logic exp_vend = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;

    sound_sequencer #(
        .CLOCK_HZ      (1000),
        .VEND_BEEP_MS  (V),
        .ERROR_BEEP_MS (E),
        .ERROR_GAP_MS  (G),
        .ERROR_BEEPS   (B)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vend_pulse  (vend_pulse),
        .error_pulse (error_pulse),
        .vend_event  (vend_event),
        .error_event (error_event),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_no, obs, exp_v);
        end
    endtask

    // Advance the model by one clock edge given the inputs sampled there.
    task automatic model_edge(input logic r, input logic v, input logic e);
        int o;
        if (r) begin
            mode = 0;
        end else if (!exp_busy) begin
            if (e) begin
                mode = 2; start_edge = edge_no;
            end else if (v) begin
                mode = 1; start_edge = edge_no;
            end
        end else if (mode == 1 && e) begin
            mode = 2; start_edge = edge_no;
        end
        exp_vend = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
        o = edge_no - start_edge;
        if (mode == 1) begin
            if (o < V) begin
                exp_vend = 1'b1; exp_busy = 1'b1;
            end else begin
                mode = 0;
            end
        end else if (mode == 2) begin
            if (o < B * E + (B - 1) * G) begin
                exp_busy = 1'b1;
                exp_err  = ((o % (E + G)) < E);
            end else begin
                mode = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic e);
        rst = r; vend_pulse = v; error_pulse = e;
        @(posedge clk);
        edge_no++;
        model_edge(r, v, e);
        #1;
        check("vend_event", 32'(vend_event), 32'(exp_vend));
        check("error_event", 32'(error_event), 32'(exp_err));
        check("busy", 32'(busy), 32'(exp_busy));
        check("no_overlap", 32'(vend_event & error_event), 32'd0);
    endtask

    int err_cycles;

    initial begin
        // Directed scenarios from the test plan, cycle numbers as in the plan.
        for (int c = 0; c < 100; c++) begin
            step(c < 3 || c == 74,
                 c == 10 || c == 12 || c == 24 || c == 40 || c == 50 || c == 78,
                 c == 20 || c == 40 || c == 52 || c == 70);
        end

        // An isolated error pattern must sound exactly B*E cycles of tone.
        err_cycles = 0;
        step(1'b0, 1'b0, 1'b1);
        if (error_event) err_cycles++;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, 1'b0);
            if (error_event) err_cycles++;
        end
        check("err_tone_total", 32'(err_cycles), 32'(B * E));

        // Random requests with occasional mid-pattern resets.
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
